dm_ctl: RTL and testbench
=========================

Name: dm_ctl

Overview:
- Debug-Module-side hart controller; the initiator end of debug_if.
- Turns DMI-level requests (haltreq, resumereq, command write, cmderr clear) into debug_if halt_req/resume_req/exec/command.
- Tracks abstract-command progress through the done/error/exception responses and maintains busy, cmderr and halt/resume-ack status for the abstractcs/dmstatus register views.

Parameters:
- TIMEOUT_CYCLES, 1024, cycle limit for one exec phase; used only with DM_CMD_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- haltreq  in  1  dmcontrol.haltreq level
- resumereq_wr  in  1  pulse; dmcontrol write with resumereq=1
- cmd_wr  in  1  pulse; command register write
- cmd_in  in  32  written command value
- cmderr_clr  in  3  abstractcs.cmderr W1C bits, applied on cmderr_clr_wr
- cmderr_clr_wr  in  1  abstractcs write strobe
- dbg_halt_req  out  1  to debug_if.halt_req
- dbg_resume_req  out  1  to debug_if.resume_req
- dbg_exec  out  1  to debug_if.exec
- dbg_command  out  32  to debug_if.command; stable while busy
- dbg_halted  in  1  from debug_if.halted
- dbg_done  in  1  from debug_if.done, single-cycle pulse
- dbg_write  in  1  from debug_if.write
- dbg_error  in  1  from debug_if.error, valid with done
- dbg_exception  in  1  from debug_if.exception, valid with done
- data_we  out  1  data0 capture strobe (dbg_write while in EXEC)
- busy  out  1  abstractcs.busy
- cmderr  out  3  abstractcs.cmderr
- allhalted  out  1  registered dbg_halted
- allresumeack  out  1  dmstatus resumeack

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; dbg_command 0; cmderr 0; resumeack 0.
- dbg_halt_req = haltreq, combinational.
- Resume:
  - resumereq_wr while dbg_halted=1 and haltreq=0 and not busy sets the resume_pend flop and clears resumeack.
  - dbg_resume_req = resume_pend.
  - The cycle after dbg_halted is seen 0 with resume_pend=1: resume_pend clears and resumeack sets.
  - resumereq_wr is ignored when not halted, when haltreq=1 (halt wins on simultaneous requests), or when busy.
- Command decode (cmdtype = cmd_in[31:24]):
  - 0 = access register: postexec = bit18, transfer = bit17.
  - 2 = access memory: postexec = 0.
  - Any other cmdtype: cmderr 2, not supported.
- FSM states: IDLE, EXEC, POST, DONE.
- From IDLE on cmd_wr, in priority order:
  - cmderr!=0: ignore.
  - Unsupported cmdtype: cmderr 2.
  - dbg_halted=0: cmderr 4.
  - Access register with transfer=0 and postexec=0: no exec, cmderr unchanged, stay IDLE.
  - Otherwise: latch cmd_in into dbg_command, then go to EXEC if transfer=1 or cmdtype 2, else POST.
- cmd_wr while busy: command dropped; cmderr becomes 1 only if it is currently 0.
- EXEC and POST:
  - dbg_exec=1, busy=1.
  - On dbg_done: if dbg_error or dbg_exception, go to DONE with the error code; else EXEC with postexec goes to POST; otherwise go to DONE.
- DONE:
  - Single cycle, busy=1, dbg_exec=0; next state IDLE, busy=0.
  - Error coding: dbg_exception gives 3. dbg_error with cmdtype 2 gives 5; with cmdtype 0 gives 3. cmderr is written only if currently 0.
- cmderr_clr_wr: cmderr &= ~cmderr_clr. A set of cmderr in the same cycle takes priority.
- dbg_done outside EXEC/POST: ignored.
- dbg_halted falling while busy: no abort; the FSM keeps waiting for done.
- Latency:
  - cmd_wr to dbg_exec: 1 cycle.
  - dbg_done to busy=0: 2 cycles.

Optional Feature:
- Macro: DM_CMD_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) resets on entering EXEC or POST and increments each busy cycle.
  - Reaching TIMEOUT_CYCLES without dbg_done forces DONE with cmderr 7, if cmderr is 0.
- Undefined: no counter; the FSM waits for dbg_done indefinitely.

Decomposition:
- Shared header debug.svh gets:
  - cmderr codes: NONE 0, BUSY 1, NOTSUP 2, EXCEPTION 3, HALTRESUME 4, BUS 5, OTHER 7.
  - A cmdtype field macro.
  - AC_POSTEXEC and AC_TRANSFER bit macros, next to the existing AC_COMMAND/AC_REG_CSR macros.
- Sub-module dm_cmd_decode, combinational: cmd_in to cmdtype-valid/postexec/needs_exec.
- FSM, resume logic and cmderr stay in dm_ctl.

Test Plan:
- Halted=1; cmd_wr 0x00221000 (access register, transfer) → next cycle dbg_exec=1, dbg_command=0x00221000. Then done pulse → busy=0 two cycles later, cmderr=0.
- Halted=1; cmd_wr 0x00261000 (transfer+postexec) → first done keeps dbg_exec=1 (POST). Second done → busy=0.
- cmd 0x02000000 (access memory); done with error=1 → cmderr=5. Then cmderr_clr=7 with cmderr_clr_wr → cmderr=0.
- dbg_halted=0; cmd_wr → cmderr=4, dbg_exec stays 0. cmd_wr while busy → cmderr=1 and the original command completes.
- Halted=1; resumereq_wr → dbg_resume_req=1. Drop halted → dbg_resume_req=0 and allresumeack=1. haltreq=1 with resumereq_wr → no resume.
- With DM_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=8: exec with no done → cmderr=7 and busy=0 after timeout. Assert rst_n=0 mid-EXEC → all outputs 0 immediately.

Source files
------------

// File: rtl/dm_ctl_pkg.sv
// Shared debug-module definitions: abstract command fields, cmderr codes, FSM states.
// The optional DM_CMD_TIMEOUT_EN build of dm_ctl uses CMDERR_OTHER for exec timeouts.
package dm_ctl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CMDERR_W  = 3;
  localparam int unsigned CMDTYPE_W = 8;

  // Abstract command field positions
  localparam int unsigned AC_CMDTYPE_LSB = 24;
  localparam int unsigned AC_POSTEXEC    = 18;
  localparam int unsigned AC_TRANSFER    = 17;

  localparam logic [CMDTYPE_W-1:0] CMDTYPE_ACCESS_REG = 8'd0;
  localparam logic [CMDTYPE_W-1:0] CMDTYPE_ACCESS_MEM = 8'd2;

  localparam logic [CMDERR_W-1:0] CMDERR_NONE       = 3'd0;
  localparam logic [CMDERR_W-1:0] CMDERR_BUSY       = 3'd1;
  localparam logic [CMDERR_W-1:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [CMDERR_W-1:0] CMDERR_EXCEPTION  = 3'd3;
  localparam logic [CMDERR_W-1:0] CMDERR_HALTRESUME = 3'd4;
  localparam logic [CMDERR_W-1:0] CMDERR_BUS        = 3'd5;
  localparam logic [CMDERR_W-1:0] CMDERR_OTHER      = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } dm_state_e;

  typedef struct packed {
    logic valid;
    logic is_mem;
    logic postexec;
    logic needs_exec;
  } cmd_dec_t;

  function automatic logic [CMDTYPE_W-1:0] cmd_type(input logic [XLEN-1:0] cmd);
    return cmd[AC_CMDTYPE_LSB +: CMDTYPE_W];
  endfunction

endpackage

// File: rtl/dm_ctl_cmd_decode.sv
// Combinational abstract-command decode: supported type, postexec and exec-phase need.
module dm_cmd_decode
  import dm_ctl_pkg::*;
(
  input  logic [XLEN-1:0] cmd_i,
  output cmd_dec_t        dec_o
);

  logic [CMDTYPE_W-1:0] ctype;

  always_comb begin
    dec_o = '0;
    ctype = cmd_type(cmd_i);
    case (ctype)
      CMDTYPE_ACCESS_REG: begin
        dec_o.valid      = 1'b1;
        dec_o.postexec   = cmd_i[AC_POSTEXEC];
        dec_o.needs_exec = cmd_i[AC_TRANSFER];
      end
      CMDTYPE_ACCESS_MEM: begin
        dec_o.valid      = 1'b1;
        dec_o.is_mem     = 1'b1;
        dec_o.needs_exec = 1'b1;
      end
      default: dec_o = '0;
    endcase
  end

endmodule

// File: rtl/dm_ctl.sv
// Debug-Module hart controller: drives debug_if halt/resume/exec and tracks abstractcs status.
// Optional exec-phase timeout is enabled by defining DM_CMD_TIMEOUT_EN.
module dm_ctl
  import dm_ctl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                haltreq,
  input  logic                resumereq_wr,
  input  logic                cmd_wr,
  input  logic [XLEN-1:0]     cmd_in,
  input  logic [CMDERR_W-1:0] cmderr_clr,
  input  logic                cmderr_clr_wr,
  output logic                dbg_halt_req,
  output logic                dbg_resume_req,
  output logic                dbg_exec,
  output logic [XLEN-1:0]     dbg_command,
  input  logic                dbg_halted,
  input  logic                dbg_done,
  input  logic                dbg_write,
  input  logic                dbg_error,
  input  logic                dbg_exception,
  output logic                data_we,
  output logic                busy,
  output logic [CMDERR_W-1:0] cmderr,
  output logic                allhalted,
  output logic                allresumeack
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("dm_ctl: TIMEOUT_CYCLES must be nonzero");
  end

  dm_state_e           state_q, state_d;
  logic [XLEN-1:0]     cmd_q, cmd_d;
  logic                postexec_q, postexec_d;
  logic                is_mem_q, is_mem_d;
  logic [CMDERR_W-1:0] cmderr_q, cmderr_d;
  logic                resume_pend_q, resume_pend_d;
  logic                resumeack_q, resumeack_d;
  logic                halted_q;
  logic                busy_q, busy_d;
  logic                exec_q, exec_d;
  logic                err_set;
  logic [CMDERR_W-1:0] err_code;
  cmd_dec_t            dec;

`ifdef DM_CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  dm_cmd_decode u_decode (
    .cmd_i (cmd_in),
    .dec_o (dec)
  );

  // Command FSM and cmderr update
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    postexec_d = postexec_q;
    is_mem_d   = is_mem_q;
    err_set    = 1'b0;
    err_code   = CMDERR_NONE;
`ifdef DM_CMD_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_wr && (cmderr_q == CMDERR_NONE)) begin
          if (!dec.valid) begin
            err_set  = 1'b1;
            err_code = CMDERR_NOTSUP;
          end else if (!dbg_halted) begin
            err_set  = 1'b1;
            err_code = CMDERR_HALTRESUME;
          end else if (dec.needs_exec || dec.postexec) begin
            cmd_d      = cmd_in;
            postexec_d = dec.postexec;
            is_mem_d   = dec.is_mem;
            state_d    = dec.needs_exec ? ST_EXEC : ST_POST;
`ifdef DM_CMD_TIMEOUT_EN
            to_cnt_d   = '0;
`endif
          end
        end
      end
      ST_EXEC, ST_POST: begin
        if (dbg_done) begin
          if (dbg_exception || dbg_error) begin
            state_d  = ST_DONE;
            err_set  = 1'b1;
            err_code = (!dbg_exception && is_mem_q) ? CMDERR_BUS : CMDERR_EXCEPTION;
          end else if ((state_q == ST_EXEC) && postexec_q) begin
            state_d = ST_POST;
`ifdef DM_CMD_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end else begin
            state_d = ST_DONE;
          end
        end
`ifdef DM_CMD_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = ST_DONE;
          err_set  = 1'b1;
          err_code = CMDERR_OTHER;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Write while busy drops the command; completion errors win the same cycle
    if ((state_q != ST_IDLE) && cmd_wr && !err_set) begin
      err_set  = 1'b1;
      err_code = CMDERR_BUSY;
    end

    cmderr_d = cmderr_q;
    if (cmderr_clr_wr) begin
      cmderr_d = cmderr_q & ~cmderr_clr;
    end
    if (err_set && (cmderr_q == CMDERR_NONE)) begin
      cmderr_d = err_code;
    end

    busy_d = (state_d != ST_IDLE);
    exec_d = (state_d == ST_EXEC) || (state_d == ST_POST);
  end

  // Resume handshake; halt request wins over a simultaneous resume
  always_comb begin
    resume_pend_d = resume_pend_q;
    resumeack_d   = resumeack_q;
    if (resumereq_wr && dbg_halted && !haltreq && !busy_q) begin
      resume_pend_d = 1'b1;
      resumeack_d   = 1'b0;
    end else if (resume_pend_q && !dbg_halted) begin
      resume_pend_d = 1'b0;
      resumeack_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      postexec_q    <= 1'b0;
      is_mem_q      <= 1'b0;
      cmderr_q      <= CMDERR_NONE;
      resume_pend_q <= 1'b0;
      resumeack_q   <= 1'b0;
      halted_q      <= 1'b0;
      busy_q        <= 1'b0;
      exec_q        <= 1'b0;
`ifdef DM_CMD_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      postexec_q    <= postexec_d;
      is_mem_q      <= is_mem_d;
      cmderr_q      <= cmderr_d;
      resume_pend_q <= resume_pend_d;
      resumeack_q   <= resumeack_d;
      halted_q      <= dbg_halted;
      busy_q        <= busy_d;
      exec_q        <= exec_d;
`ifdef DM_CMD_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  assign dbg_halt_req   = haltreq;
  assign dbg_resume_req = resume_pend_q;
  assign dbg_exec       = exec_q;
  assign dbg_command    = cmd_q;
  assign data_we        = dbg_write && (state_q == ST_EXEC);
  assign busy           = busy_q;
  assign cmderr         = cmderr_q;
  assign allhalted      = halted_q;
  assign allresumeack   = resumeack_q;

endmodule

// File: tb/tb_dm_ctl.sv
// Directed self-checking bench for dm_ctl: commands, errors, resume and async reset.
module tb_dm_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        haltreq, resumereq_wr, cmd_wr, cmderr_clr_wr;
  logic [31:0] cmd_in;
  logic [2:0]  cmderr_clr;
  logic        dbg_halt_req, dbg_resume_req, dbg_exec;
  logic [31:0] dbg_command;
  logic        dbg_halted, dbg_done, dbg_write, dbg_error, dbg_exception;
  logic        data_we, busy, allhalted, allresumeack;
  logic [2:0]  cmderr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_ctl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .haltreq(haltreq), .resumereq_wr(resumereq_wr),
    .cmd_wr(cmd_wr), .cmd_in(cmd_in), .cmderr_clr(cmderr_clr), .cmderr_clr_wr(cmderr_clr_wr),
    .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req), .dbg_exec(dbg_exec),
    .dbg_command(dbg_command), .dbg_halted(dbg_halted), .dbg_done(dbg_done),
    .dbg_write(dbg_write), .dbg_error(dbg_error), .dbg_exception(dbg_exception),
    .data_we(data_we), .busy(busy), .cmderr(cmderr), .allhalted(allhalted),
    .allresumeack(allresumeack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] c);
    cmd_in = c;
    cmd_wr = 1'b1;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic done_pulse(input logic err, input logic exc);
    dbg_done = 1'b1; dbg_error = err; dbg_exception = exc;
    tick();
    dbg_done = 1'b0; dbg_error = 1'b0; dbg_exception = 1'b0;
  endtask

  task automatic clr_err();
    cmderr_clr = 3'b111; cmderr_clr_wr = 1'b1;
    tick();
    cmderr_clr = 3'b000; cmderr_clr_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; haltreq = 1'b0; resumereq_wr = 1'b0; cmd_wr = 1'b0; cmd_in = '0;
    cmderr_clr = '0; cmderr_clr_wr = 1'b0; dbg_halted = 1'b0; dbg_done = 1'b0;
    dbg_write = 1'b0; dbg_error = 1'b0; dbg_exception = 1'b0;
    #12;
    checks++;
    if ({dbg_resume_req, dbg_exec, busy, allhalted, allresumeack, data_we} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000",
        {dbg_resume_req, dbg_exec, busy, allhalted, allresumeack, data_we});
    end
    checks++;
    if ({dbg_command, cmderr} !== 35'h0) begin
      failures++; $display("FAIL reset_cmd got=%h/%0d exp=0/0", dbg_command, cmderr);
    end
    tick();
    rst_n = 1'b1;
    dbg_halted = 1'b1;
    tick();
    checks++;
    if (allhalted !== 1'b1) begin
      failures++; $display("FAIL allhalted got=%b exp=1", allhalted);
    end
  endtask

  task automatic test_access_reg();
    issue(32'h0022_1000);
    checks++;
    if ({dbg_exec, busy} !== 2'b11 || dbg_command !== 32'h0022_1000) begin
      failures++; $display("FAIL reg_exec got=%b%b cmd=%h exp=11 cmd=00221000", dbg_exec, busy, dbg_command);
    end
    dbg_write = 1'b1;
    #1;
    checks++;
    if (data_we !== 1'b1) begin
      failures++; $display("FAIL data_we got=%b exp=1", data_we);
    end
    dbg_write = 1'b0;
    done_pulse(1'b0, 1'b0);
    checks++;
    if ({dbg_exec, busy} !== 2'b01) begin
      failures++; $display("FAIL reg_done_state got=%b%b exp=01", dbg_exec, busy);
    end
    tick();
    checks++;
    if ({busy, cmderr} !== 4'b0000) begin
      failures++; $display("FAIL reg_idle got=busy%b err%0d exp=busy0 err0", busy, cmderr);
    end
  endtask

  task automatic test_postexec();
    issue(32'h0026_1000);
    done_pulse(1'b0, 1'b0);
    checks++;
    if ({dbg_exec, busy} !== 2'b11) begin
      failures++; $display("FAIL post_phase got=%b%b exp=11", dbg_exec, busy);
    end
    dbg_write = 1'b1;
    #1;
    checks++;
    if (data_we !== 1'b0) begin
      failures++; $display("FAIL post_data_we got=%b exp=0", data_we);
    end
    dbg_write = 1'b0;
    done_pulse(1'b0, 1'b0);
    tick();
    checks++;
    if ({dbg_exec, busy, cmderr} !== 5'b0) begin
      failures++; $display("FAIL post_idle got=%b%b err%0d exp=00 err0", dbg_exec, busy, cmderr);
    end
  endtask

  task automatic test_errors();
    issue(32'h0200_0000);
    done_pulse(1'b1, 1'b0);
    tick();
    checks++;
    if ({busy, cmderr} !== {1'b0, 3'd5}) begin
      failures++; $display("FAIL mem_bus_err got=busy%b err%0d exp=busy0 err5", busy, cmderr);
    end
    clr_err();
    checks++;
    if (cmderr !== 3'd0) begin
      failures++; $display("FAIL cmderr_clear got=%0d exp=0", cmderr);
    end
    issue(32'h0022_1000);
    done_pulse(1'b1, 1'b1);
    tick();
    checks++;
    if (cmderr !== 3'd3) begin
      failures++; $display("FAIL exception_err got=%0d exp=3", cmderr);
    end
    clr_err();
    issue(32'h0500_0000);
    checks++;
    if ({busy, cmderr} !== {1'b0, 3'd2}) begin
      failures++; $display("FAIL notsup got=busy%b err%0d exp=busy0 err2", busy, cmderr);
    end
    issue(32'h0022_1000);
    checks++;
    if ({dbg_exec, busy, cmderr} !== {2'b00, 3'd2}) begin
      failures++; $display("FAIL sticky_ignore got=%b%b err%0d exp=00 err2", dbg_exec, busy, cmderr);
    end
    clr_err();
    issue(32'h0000_1000);
    checks++;
    if ({dbg_exec, busy, cmderr} !== 5'b0) begin
      failures++; $display("FAIL noop_reg got=%b%b err%0d exp=00 err0", dbg_exec, busy, cmderr);
    end
    done_pulse(1'b1, 1'b0);
    checks++;
    if ({busy, cmderr} !== 4'b0) begin
      failures++; $display("FAIL idle_done got=busy%b err%0d exp=busy0 err0", busy, cmderr);
    end
  endtask

  task automatic test_halt_and_busy();
    dbg_halted = 1'b0;
    issue(32'h0022_1000);
    checks++;
    if ({dbg_exec, cmderr} !== {1'b0, 3'd4}) begin
      failures++; $display("FAIL not_halted got=exec%b err%0d exp=exec0 err4", dbg_exec, cmderr);
    end
    clr_err();
    dbg_halted = 1'b1;
    issue(32'h0022_1000);
    issue(32'h0200_0000);
    checks++;
    if (cmderr !== 3'd1 || dbg_command !== 32'h0022_1000 || dbg_exec !== 1'b1) begin
      failures++; $display("FAIL busy_write got=err%0d cmd=%h exec%b exp=err1 cmd=00221000 exec1",
        cmderr, dbg_command, dbg_exec);
    end
    dbg_halted = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL no_abort got=%b exp=1", busy);
    end
    dbg_halted = 1'b1;
    done_pulse(1'b0, 1'b0);
    tick();
    checks++;
    if ({busy, cmderr} !== {1'b0, 3'd1}) begin
      failures++; $display("FAIL busy_complete got=busy%b err%0d exp=busy0 err1", busy, cmderr);
    end
    clr_err();
  endtask

  task automatic test_resume();
    resumereq_wr = 1'b1;
    tick();
    resumereq_wr = 1'b0;
    checks++;
    if ({dbg_resume_req, allresumeack} !== 2'b10) begin
      failures++; $display("FAIL resume_req got=%b%b exp=10", dbg_resume_req, allresumeack);
    end
    dbg_halted = 1'b0;
    tick();
    checks++;
    if ({dbg_resume_req, allresumeack, allhalted} !== 3'b010) begin
      failures++; $display("FAIL resume_ack got=%b exp=010", {dbg_resume_req, allresumeack, allhalted});
    end
    resumereq_wr = 1'b1;
    tick();
    checks++;
    if ({dbg_resume_req, allresumeack} !== 2'b01) begin
      failures++; $display("FAIL resume_not_halted got=%b%b exp=01", dbg_resume_req, allresumeack);
    end
    dbg_halted = 1'b1;
    haltreq = 1'b1;
    tick();
    resumereq_wr = 1'b0;
    checks++;
    if ({dbg_resume_req, allresumeack, dbg_halt_req} !== 3'b011) begin
      failures++; $display("FAIL halt_wins got=%b exp=011", {dbg_resume_req, allresumeack, dbg_halt_req});
    end
    haltreq = 1'b0;
    #1;
    checks++;
    if (dbg_halt_req !== 1'b0) begin
      failures++; $display("FAIL halt_req_follow got=%b exp=0", dbg_halt_req);
    end
  endtask

`ifdef DM_CMD_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    issue(32'h0022_1000);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || cmderr !== 3'd7) begin
      failures++; $display("FAIL timeout got=busy%b err%0d after %0d exp=busy0 err7", busy, cmderr, n);
    end
    clr_err();
  endtask
`endif

  task automatic test_reset_mid_exec();
    issue(32'h0022_1000);
    issue(32'h0022_1000);
    resumereq_wr = 1'b0;
    checks++;
    if ({busy, cmderr} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL pre_reset got=busy%b err%0d exp=busy1 err1", busy, cmderr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dbg_resume_req, dbg_exec, busy, allhalted, allresumeack, data_we, cmderr} !== 9'b0 ||
        dbg_command !== 32'h0) begin
      failures++; $display("FAIL async_reset got=%b err%0d cmd=%h exp=all zero",
        {dbg_resume_req, dbg_exec, busy, allhalted, allresumeack, data_we}, cmderr, dbg_command);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_access_reg();
    test_postexec();
    test_errors();
    test_halt_and_busy();
    test_resume();
`ifdef DM_CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
